// File: rtl/sent_tx_pulse_gen.sv
// SENT line encoder: latches one fast-channel frame and serialises it
// as tick-timed pulses (sync, status, 6 data, CRC, optional pause).
module sent_tx_pulse_gen #(
  parameter int TICK_DIV  = 3,
  parameter int PAUSE_LEN = 0
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        frame_start,
  input  logic [3:0]  status_nib,
  input  logic [23:0] data_nibs,
  input  logic [3:0]  crc_nib,
  output logic        ready,
  output logic        data_pulse,
  output logic [2:0]  nib_idx,
  output logic        frame_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, SYNC, STATUS, DATA, CRC, PAUSE
  } state_t;

  state_t state, state_nx;

  logic [3:0]    st_q;
  logic [23:0]   data_q;
  logic [3:0]    crc_q;
  logic [2:0]    dcnt;
  logic [PW-1:0] presc;
  logic [9:0]    ticks;
  logic [3:0]    cur_nib;
  logic [9:0]    pulse_len;
  logic          tick;
  logic          pulse_end;
  logic          accept;

  assign accept = (state == IDLE) && frame_start;
  assign tick   = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    cur_nib = 4'd0;
    unique case (dcnt)
      3'd1:    cur_nib = data_q[23:20];
      3'd2:    cur_nib = data_q[19:16];
      3'd3:    cur_nib = data_q[15:12];
      3'd4:    cur_nib = data_q[11:8];
      3'd5:    cur_nib = data_q[7:4];
      3'd6:    cur_nib = data_q[3:0];
      default: cur_nib = 4'd0;
    endcase
    if (state == STATUS) cur_nib = st_q;
    if (state == CRC)    cur_nib = crc_q;
  end

  always_comb begin
    pulse_len = 10'd0;
    unique case (state)
      SYNC:               pulse_len = 10'd56;
      STATUS, DATA, CRC:  pulse_len = 10'd12 + {6'd0, cur_nib};
      PAUSE:              pulse_len = 10'(PAUSE_LEN);
      default:            pulse_len = 10'd0;
    endcase
  end

  assign pulse_end = (state != IDLE) && tick &&
                     (ticks == pulse_len - 10'd1);

  always_ff @(posedge clk_tx or negedge reset_tx) begin
    if (!reset_tx) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ready      = 1'b0;
    frame_done = 1'b0;
    nib_idx    = 3'd0;
    data_pulse = (ticks >= 10'd5);
    unique case (state)
      IDLE: begin
        ready      = 1'b1;
        data_pulse = 1'b1;
        if (frame_start) state_nx = SYNC;
      end
      SYNC: begin
        if (pulse_end) state_nx = STATUS;
      end
      STATUS: begin
        if (pulse_end) state_nx = DATA;
      end
      DATA: begin
        nib_idx = dcnt;
        if (pulse_end && dcnt == 3'd6) state_nx = CRC;
      end
      CRC: begin
        nib_idx = 3'd7;
        if (pulse_end) begin
          if (PAUSE_LEN != 0) begin
            state_nx = PAUSE;
          end else begin
            state_nx   = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (pulse_end) begin
          state_nx   = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tick prescaler, per-pulse tick counter and data nibble pointer
  always_ff @(posedge clk_tx or negedge reset_tx) begin
    if (!reset_tx) begin
      st_q   <= '0;
      data_q <= '0;
      crc_q  <= '0;
      dcnt   <= '0;
      presc  <= '0;
      ticks  <= '0;
    end else if (accept) begin
      st_q   <= status_nib;
      data_q <= data_nibs;
      crc_q  <= crc_nib;
      dcnt   <= 3'd1;
      presc  <= '0;
      ticks  <= '0;
    end else if (state != IDLE) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (pulse_end) begin
        ticks <= '0;
        if (state == DATA) dcnt <= dcnt + 3'd1;
      end else if (tick) begin
        ticks <= ticks + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Directed bench for sent_tx_pulse_gen: three parameterisations
// checked for pulse lengths, low widths, nibble index and frame_done.
module tb_sent_tx_pulse_gen;

  logic        clk;
  logic        fs  [3];
  logic        rst [3];
  logic [3:0]  status;
  logic [23:0] data;
  logic [3:0]  crc;
  logic        rdy [3];
  logic        dp  [3];
  logic [2:0]  nidx[3];
  logic        fd  [3];

  int checks;
  int errors;
  int np;
  int done_at;
  int starts [16];
  int lows   [16];
  int nibs   [16];
  int exp_len[10];
  int exp_nib[10];
  int exp_n;

  sent_tx_pulse_gen #(.TICK_DIV(1), .PAUSE_LEN(0)) u0 (
    .clk_tx(clk), .reset_tx(rst[0]), .frame_start(fs[0]),
    .status_nib(status), .data_nibs(data), .crc_nib(crc),
    .ready(rdy[0]), .data_pulse(dp[0]), .nib_idx(nidx[0]),
    .frame_done(fd[0])
  );

  sent_tx_pulse_gen #(.TICK_DIV(3), .PAUSE_LEN(0)) u1 (
    .clk_tx(clk), .reset_tx(rst[1]), .frame_start(fs[1]),
    .status_nib(status), .data_nibs(data), .crc_nib(crc),
    .ready(rdy[1]), .data_pulse(dp[1]), .nib_idx(nidx[1]),
    .frame_done(fd[1])
  );

  sent_tx_pulse_gen #(.TICK_DIV(1), .PAUSE_LEN(100)) u2 (
    .clk_tx(clk), .reset_tx(rst[2]), .frame_start(fs[2]),
    .status_nib(status), .data_nibs(data), .crc_nib(crc),
    .ready(rdy[2]), .data_pulse(dp[2]), .nib_idx(nidx[2]),
    .frame_done(fd[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [3:0] s, input logic [23:0] d,
                         input logic [3:0] c, input int pause);
    logic [23:0] dd;
    dd = d;
    exp_len[0] = 56;
    exp_len[1] = 12 + int'(s);
    for (int i = 0; i < 6; i++) begin
      exp_len[2 + i] = 12 + int'(dd[23:20]);
      dd = dd << 4;
    end
    exp_len[8] = 12 + int'(c);
    exp_len[9] = pause;
    exp_n = (pause != 0) ? 10 : 9;
  endtask

  task automatic start(input int k);
    @(negedge clk);
    fs[k] = 1'b1;
    @(posedge clk);
    #1 fs[k] = 1'b0;
  endtask

  // Samples the line once per cycle from the first cycle after acceptance
  task automatic capture(input int k, input int maxc, input bit scr);
    int prev;
    prev = 1;
    np = 0;
    done_at = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("first_low", int'(dp[k]), 0);
        chk("busy", int'(rdy[k]), 0);
      end
      if (dp[k] == 1'b0 && prev == 1 && np < 16) begin
        starts[np] = c;
        lows[np] = 0;
        nibs[np] = int'(nidx[k]);
        np++;
      end
      if (dp[k] == 1'b0 && np > 0) lows[np-1]++;
      prev = int'(dp[k]);
      if (scr) begin
        status = 4'($urandom);
        data   = 24'($urandom);
        crc    = 4'($urandom);
      end
      if (fd[k]) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic verify(input string name, input int td, input int done_exp);
    int len;
    chk($sformatf("%s_pulses", name), np, exp_n);
    for (int i = 0; i < exp_n && i < np; i++) begin
      len = (i < np - 1) ? starts[i+1] - starts[i]
                         : done_at - starts[i] + 1;
      chk($sformatf("%s_len%0d", name, i), len, exp_len[i] * td);
      chk($sformatf("%s_low%0d", name, i), lows[i], 5 * td);
      chk($sformatf("%s_nib%0d", name, i), nibs[i], exp_nib[i]);
    end
    chk($sformatf("%s_done", name), done_at, done_exp);
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    status = '0;
    data = '0;
    crc = '0;
    exp_nib = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    for (int k = 0; k < 3; k++) begin
      fs[k] = 1'b0;
      rst[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), int'(rdy[k]), 1);
      chk($sformatf("rst_line%0d", k), int'(dp[k]), 1);
      chk($sformatf("rst_nib%0d", k), int'(nidx[k]), 0);
      chk($sformatf("rst_done%0d", k), int'(fd[k]), 0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero frame, one clock per tick
    start(0);
    capture(0, 400, 1'b0);
    set_exp(4'h0, 24'h0, 4'h0, 0);
    verify("t1", 1, 152);
    @(negedge clk);
    chk("t1_ready_after", int'(rdy[0]), 1);
    chk("t1_line_after", int'(dp[0]), 1);

    // Mixed nibbles, three clocks per tick
    status = 4'hF;
    data = 24'h123456;
    crc = 4'hA;
    start(1);
    capture(1, 1000, 1'b0);
    set_exp(4'hF, 24'h123456, 4'hA, 0);
    verify("t2", 3, 594);

    // Pause pulse appended
    status = '0;
    data = '0;
    crc = '0;
    start(2);
    capture(2, 400, 1'b0);
    set_exp(4'h0, 24'h0, 4'h0, 100);
    verify("t3", 1, 252);

    // frame_start held high: mid-frame requests ignored, one idle cycle
    set_exp(4'h0, 24'h0, 4'h0, 0);
    @(negedge clk);
    fs[0] = 1'b1;
    @(posedge clk);
    capture(0, 400, 1'b0);
    verify("t4a", 1, 152);
    @(negedge clk);
    chk("t4_gap_ready", int'(rdy[0]), 1);
    chk("t4_gap_line", int'(dp[0]), 1);
    @(posedge clk);
    #1 fs[0] = 1'b0;
    capture(0, 400, 1'b0);
    verify("t4b", 1, 152);

    // Inputs scrambled every cycle after acceptance
    status = 4'h0;
    data = 24'hF0F0F0;
    crc = 4'h5;
    start(1);
    capture(1, 1000, 1'b1);
    set_exp(4'h0, 24'hF0F0F0, 4'h5, 0);
    verify("t5", 3, 606);

    // Reset during DATA3 aborts, then a clean frame
    status = '0;
    data = '0;
    crc = '0;
    start(1);
    repeat (280) @(negedge clk);
    chk("t6_in_data3", int'(nidx[1]), 3);
    rst[1] = 1'b0;
    #1;
    chk("t6_rst_line", int'(dp[1]), 1);
    chk("t6_rst_ready", int'(rdy[1]), 1);
    chk("t6_rst_nib", int'(nidx[1]), 0);
    chk("t6_rst_done", int'(fd[1]), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_done", int'(fd[1]), 0);
      chk("t6_hold_line", int'(dp[1]), 1);
    end
    rst[1] = 1'b1;
    start(1);
    capture(1, 1000, 1'b0);
    set_exp(4'h0, 24'h0, 4'h0, 0);
    verify("t6", 3, 456);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
